// File: rtl/io_responder.sv
// Peripheral end of the CPU memory/IO path: LED register, debounced switch readback,
// and a multiplexed 8-digit seven-segment display (LEDs on digits 0-3, switches on 4-7).
module io_responder #(
    parameter int SCAN_DIV  = 100000,
    parameter int DB_CYCLES = 500000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        led_ctrl,
    input  logic        switch_ctrl,
    input  logic [15:0] io_wdata,
    output logic [15:0] io_rdata,
    input  logic [15:0] switch_in,
    output logic [15:0] led_out,
    output logic [7:0]  seg_an,
    output logic [7:0]  seg_out
);
    localparam int SCAN_W = $clog2(SCAN_DIV);
    localparam int DB_W   = $clog2(DB_CYCLES);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);

    logic [15:0]       led_q, led_d;
    logic [15:0]       sync1_q, sync1_d;
    logic [15:0]       sync2_q, sync2_d;
    logic [15:0]       cand_q, cand_d;
    logic [15:0]       sw_stable_q, sw_stable_d;
    logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
    logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [2:0]        digit_q, digit_d;

    // Strobes are single-cycle selects with no handshake: the CPU holds the
    // access for one cycle and both strobes may be serviced in the same cycle.
    always_comb begin
        led_d       = led_q;
        sync1_d     = switch_in;
        sync2_d     = sync1_q;
        cand_d      = cand_q;
        sw_stable_d = sw_stable_q;
        db_cnt_d    = db_cnt_q;
        scan_cnt_d  = scan_cnt_q;
        digit_d     = digit_q;

        if (led_ctrl) begin
            led_d = io_wdata;
        end

        // Whole-vector debounce; the counter saturates once the candidate is accepted.
        if (sync2_q != cand_q) begin
            cand_d   = sync2_q;
            db_cnt_d = '0;
        end else if (db_cnt_q < DB_LAST) begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end else begin
            sw_stable_d = cand_q;
        end

        if (scan_cnt_q == SCAN_LAST) begin
            scan_cnt_d = '0;
            digit_d    = digit_q + 3'd1;
        end else begin
            scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            led_q       <= '0;
            sync1_q     <= '0;
            sync2_q     <= '0;
            cand_q      <= '0;
            sw_stable_q <= '0;
            db_cnt_q    <= '0;
            scan_cnt_q  <= '0;
            digit_q     <= '0;
        end else begin
            led_q       <= led_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cand_q      <= cand_d;
            sw_stable_q <= sw_stable_d;
            db_cnt_q    <= db_cnt_d;
            scan_cnt_q  <= scan_cnt_d;
            digit_q     <= digit_d;
        end
    end

    assign led_out  = led_q;
    assign io_rdata = switch_ctrl ? sw_stable_q : 16'h0000;
    assign seg_an   = ~(8'b0000_0001 << digit_q);

    logic [15:0] disp_word;
    logic [3:0]  nibble;

    always_comb begin
        disp_word = digit_q[2] ? sw_stable_q : led_q;
        nibble    = 4'(disp_word >> {digit_q[1:0], 2'b00});
        case (nibble)
            4'h0:    seg_out = 8'hC0;
            4'h1:    seg_out = 8'hF9;
            4'h2:    seg_out = 8'hA4;
            4'h3:    seg_out = 8'hB0;
            4'h4:    seg_out = 8'h99;
            4'h5:    seg_out = 8'h92;
            4'h6:    seg_out = 8'h82;
            4'h7:    seg_out = 8'hF8;
            4'h8:    seg_out = 8'h80;
            4'h9:    seg_out = 8'h90;
            4'hA:    seg_out = 8'h88;
            4'hB:    seg_out = 8'h83;
            4'hC:    seg_out = 8'hC6;
            4'hD:    seg_out = 8'hA1;
            4'hE:    seg_out = 8'h86;
            default: seg_out = 8'h8E;
        endcase
    end
endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder with short scan and debounce windows.
module tb_io_responder;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        led_ctrl;
    logic        switch_ctrl;
    logic [15:0] io_wdata;
    logic [15:0] io_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [7:0]  seg_an;
    logic [7:0]  seg_out;

    int n_checks = 0;
    int n_fail   = 0;

    io_responder #(.SCAN_DIV(4), .DB_CYCLES(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .led_ctrl    (led_ctrl),
        .switch_ctrl (switch_ctrl),
        .io_wdata    (io_wdata),
        .io_rdata    (io_rdata),
        .switch_in   (switch_in),
        .led_out     (led_out),
        .seg_an      (seg_an),
        .seg_out     (seg_out)
    );

    always #5 clk = ~clk;

    // Apply one reset edge with the given switch value and quiet strobes.
    task automatic do_reset(input logic [15:0] sw);
        rst_n       = 1'b0;
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        io_wdata    = 16'h0000;
        switch_in   = sw;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        led_ctrl    = 1'b1;
        switch_ctrl = 1'b1;
        io_wdata    = 16'hFFFF;
        switch_in   = 16'hFFFF;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (led_out !== 16'h0000) begin
            n_fail++; $display("FAIL reset_led_out got=%h exp=0000", led_out);
        end
        n_checks++;
        if (seg_an !== 8'hFE) begin
            n_fail++; $display("FAIL reset_seg_an got=%h exp=fe", seg_an);
        end
        n_checks++;
        if (seg_out !== 8'hC0) begin
            n_fail++; $display("FAIL reset_seg_out got=%h exp=c0", seg_out);
        end
        n_checks++;
        if (io_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL reset_io_rdata got=%h exp=0000", io_rdata);
        end
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        switch_in   = 16'h0000;
        rst_n       = 1'b1;
    endtask

    task automatic test_led_write();
        // A5C3 nibbles [3:0],[7:4],[11:8],[15:12] = 3,C,5,A.
        logic [7:0] led_seg [4] = '{8'hB0, 8'hC6, 8'h92, 8'h88};
        logic [7:0] one = 8'h01;
        logic [7:0] exp_an;
        logic [7:0] exp_seg;
        int d;
        do_reset(16'h0000);
        led_ctrl = 1'b1;
        io_wdata = 16'hA5C3;
        @(negedge clk);
        led_ctrl = 1'b0;
        io_wdata = 16'h0000;
        n_checks++;
        if (led_out !== 16'hA5C3) begin
            n_fail++; $display("FAIL led_write got=%h exp=a5c3", led_out);
        end
        // n counts edges since reset release; each digit is lit for 4 edges.
        for (int n = 1; n <= 36; n++) begin
            d       = (n / 4) % 8;
            exp_an  = ~(one << d);
            exp_seg = (d < 4) ? led_seg[d] : 8'hC0;
            n_checks++;
            if (seg_an !== exp_an) begin
                n_fail++; $display("FAIL scan_an n=%0d got=%h exp=%h", n, seg_an, exp_an);
            end
            n_checks++;
            if (seg_out !== exp_seg) begin
                n_fail++; $display("FAIL scan_seg n=%0d got=%h exp=%h", n, seg_out, exp_seg);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_debounce_accept();
        logic [15:0] exp;
        do_reset(16'h0000);
        switch_in   = 16'h1234;
        switch_ctrl = 1'b1;
        for (int e = 1; e <= 9; e++) begin
            @(negedge clk);
            exp = (e >= 7) ? 16'h1234 : 16'h0000;
            n_checks++;
            if (io_rdata !== exp) begin
                n_fail++; $display("FAIL db_accept edge=%0d got=%h exp=%h", e, io_rdata, exp);
            end
        end
        switch_ctrl = 1'b0;
        #1;
        n_checks++;
        if (io_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL db_no_select got=%h exp=0000", io_rdata);
        end
        // Digit 4 shows sw_stable[3:0]=4 once the scan reaches it.
        for (int e = 0; e < 32; e++) begin
            if (seg_an == 8'hEF) break;
            @(negedge clk);
        end
        n_checks++;
        if (seg_an !== 8'hEF || seg_out !== 8'h99) begin
            n_fail++; $display("FAIL db_digit4 got an=%h seg=%h exp an=ef seg=99", seg_an, seg_out);
        end
    endtask

    task automatic test_glitch_reject();
        do_reset(16'h0000);
        switch_ctrl = 1'b1;
        repeat (5) @(negedge clk);
        switch_in = 16'h00FF;
        repeat (3) @(negedge clk);
        switch_in = 16'h0000;
        for (int e = 1; e <= 10; e++) begin
            @(negedge clk);
            n_checks++;
            if (io_rdata !== 16'h0000) begin
                n_fail++; $display("FAIL glitch edge=%0d got=%h exp=0000", e, io_rdata);
            end
        end
        switch_ctrl = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset(16'h00F0);
        repeat (8) @(negedge clk);
        led_ctrl    = 1'b1;
        switch_ctrl = 1'b1;
        io_wdata    = 16'hBEEF;
        #1;
        n_checks++;
        if (io_rdata !== 16'h00F0) begin
            n_fail++; $display("FAIL simul_rdata got=%h exp=00f0", io_rdata);
        end
        @(negedge clk);
        led_ctrl = 1'b0;
        n_checks++;
        if (led_out !== 16'hBEEF) begin
            n_fail++; $display("FAIL simul_led got=%h exp=beef", led_out);
        end
        n_checks++;
        if (io_rdata !== 16'h00F0) begin
            n_fail++; $display("FAIL simul_rdata_after got=%h exp=00f0", io_rdata);
        end
        // Back-to-back writes: the last one wins.
        led_ctrl = 1'b1;
        io_wdata = 16'h1111;
        @(negedge clk);
        io_wdata = 16'h2222;
        @(negedge clk);
        led_ctrl = 1'b0;
        io_wdata = 16'h3333;
        @(negedge clk);
        n_checks++;
        if (led_out !== 16'h2222) begin
            n_fail++; $display("FAIL back_to_back got=%h exp=2222", led_out);
        end
        switch_ctrl = 1'b0;
    endtask

    task automatic test_reset_mid_debounce();
        logic [15:0] exp;
        do_reset(16'h0000);
        switch_ctrl = 1'b1;
        switch_in   = 16'h5A5A;
        repeat (4) @(negedge clk);
        n_checks++;
        if (io_rdata !== 16'h0000) begin
            n_fail++; $display("FAIL mid_before_rst got=%h exp=0000", io_rdata);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(negedge clk);
            exp = (e >= 7) ? 16'h5A5A : 16'h0000;
            n_checks++;
            if (io_rdata !== exp) begin
                n_fail++; $display("FAIL mid_rst_reaccept edge=%0d got=%h exp=%h", e, io_rdata, exp);
            end
        end
        switch_ctrl = 1'b0;
    endtask

    initial begin
        rst_n       = 1'b0;
        led_ctrl    = 1'b0;
        switch_ctrl = 1'b0;
        io_wdata    = 16'h0000;
        switch_in   = 16'h0000;
        @(negedge clk);
        test_reset();
        test_led_write();
        test_debounce_accept();
        test_glitch_reject();
        test_simultaneous();
        test_reset_mid_debounce();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
